// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings, lane masks and alignment check for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_ALL = 4'b1111;
    function automatic logic misaligned(size_e sz, logic [1:0] off);
        return sz == SZ_RSVD || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: size/offset -> byte enables (be_o), replicated store data (wdata_o), extended load data (rdata_o)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] sh;
    assign sh      = rdata_i >> {off_i, 3'b000};
    assign be_o    = size_i == SZ_BYTE ? 4'b0001 << off_i :
                     size_i == SZ_HALF ? (off_i[1] ? BE_HI : BE_LO) :
                     size_i == SZ_WORD ? BE_ALL : 4'b0000;
    assign wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                     size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    assign rdata_o = size_i == SZ_BYTE ? {{24{signed_i & sh[7]}}, sh[7:0]} :
                     size_i == SZ_HALF ? {{16{signed_i & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time CPU req_*/resp_* to stalling word memory mem_* bridge with timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [3:0]  mem_byteenable_o,
    output logic [31:0] mem_writedata_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_waitrequest_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_e      state_q, state_d;
    size_e       size_q;
    logic        write_q, signed_q, acc, accept;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, ld_data, st_data;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  be;
    lsu_lane_align u_align (
        .size_i   (size_q),
        .off_i    (addr_q[1:0]),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_readdata_i),
        .be_o     (be),
        .wdata_o  (st_data),
        .rdata_o  (ld_data)
    );
    assign acc    = state_q == ACCESS;
    assign accept = state_q == IDLE && req_valid_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid_i) state_d = misaligned(size_e'(req_size_i), req_addr_i[1:0]) ? ERR : ACCESS;
            end
            ACCESS: begin
                // completion wins over timeout when both happen on the limit cycle
                if (!mem_waitrequest_i) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : ld_data;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) state_d = ERR;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                write_q  <= req_write_i;
                size_q   <= size_e'(req_size_i);
                signed_q <= req_signed_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
        end
    end
    // memory-side outputs are gated by ACCESS so they read zero whenever no strobe is up
    assign req_ready_o      = state_q == IDLE;
    assign resp_valid_o     = state_q == RESP || state_q == ERR;
    assign resp_err_o       = state_q == ERR;
    assign resp_rdata_o     = state_q == RESP ? rdata_q : '0;
    assign mem_read_o       = acc & ~write_q;
    assign mem_write_o      = acc & write_q;
    assign mem_addr_o       = acc ? {addr_q[31:2], 2'b00} : '0;
    assign mem_byteenable_o = acc ? be : '0;
    assign mem_writedata_o  = acc ? st_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int TO = 4;
    typedef struct {
        bit        write;
        bit [1:0]  size;
        bit        sgn;
        bit [31:0] addr, wdata, mdata;
        int        stall;
        bit [3:0]  be;
        bit [31:0] wd, rdata;
        bit        err;
        int        cyc, nstb;
    } vec_t;
    logic        clk, rst_n, req_valid, req_ready, req_write, req_signed, resp_valid, resp_err;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [1:0]  req_size;
    logic [3:0]  mem_be;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wd, mem_rd;
    int total = 0, bad = 0;
    vec_t tbl[12];
    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_write_i       (req_write),
        .req_size_i        (req_size),
        .req_signed_i      (req_signed),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_err_o        (resp_err),
        .mem_addr_o        (mem_addr),
        .mem_read_o        (mem_read),
        .mem_write_o       (mem_write),
        .mem_byteenable_o  (mem_be),
        .mem_writedata_o   (mem_wd),
        .mem_readdata_i    (mem_rd),
        .mem_waitrequest_i (mem_waitrequest)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(bit w, bit [1:0] sz, bit sg, bit [31:0] a, bit [31:0] wdat, bit [31:0] md,
                                int st, bit [3:0] be, bit [31:0] wd, bit [31:0] rd, bit e, int cy, int ns);
        vec_t v;
        v.write = w; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wdat; v.mdata = md; v.stall = st;
        v.be = be; v.wd = wd; v.rdata = rd; v.err = e; v.cyc = cy; v.nstb = ns;
        return v;
    endfunction
    function automatic vec_t predict(vec_t v);
        int nb, off;
        longint val, lim;
        nb = v.size == 0 ? 1 : v.size == 1 ? 2 : v.size == 2 ? 4 : 0;
        off = int'(v.addr % 4);
        v.be = 0; v.wd = 0; v.rdata = 0;
        if (nb == 0 || off % nb != 0) begin
            v.err = 1; v.nstb = 0; v.cyc = 1;
            return v;
        end
        for (int i = 0; i < nb; i++) v.be[off + i] = 1'b1;
        for (int n = 0; n < 4; n++) v.wd[8*n +: 8] = v.wdata[8*(n % nb) +: 8];
        v.err = v.stall > TO;
        v.nstb = (v.stall > TO ? TO : v.stall) + 1;
        v.cyc = v.nstb + 1;
        if (!v.write && !v.err) begin
            lim = 64'sd1 << (8 * nb);
            val = (longint'(v.mdata) >> (8 * off)) % lim;
            if (v.sgn && nb < 4 && val >= lim / 2) val -= lim;
            v.rdata = val[31:0];
        end
        return v;
    endfunction
    task automatic do_txn(input vec_t v);
        int idx, unstable, both;
        bit got;
        logic [31:0] a0, w0;
        logic [3:0] b0;
        logic wr0;
        idx = 0; unstable = 0; both = 0; got = 0;
        a0 = 0; w0 = 0; b0 = 0; wr0 = 0;
        req_valid = 1; req_write = v.write; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        chk("ready_at_accept", req_ready, 1);
        @(posedge clk); #1;
        for (int c = 1; c <= 40 && !got; c++) begin
            req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            if (mem_read && mem_write) both++;
            if (mem_read || mem_write) begin
                idx++;
                if (idx == 1) begin
                    a0 = mem_addr; b0 = mem_be; w0 = mem_wd; wr0 = mem_write;
                end else if (mem_addr !== a0 || mem_be !== b0 || mem_wd !== w0 || mem_write !== wr0) unstable++;
                mem_waitrequest = idx <= v.stall;
            end else mem_waitrequest = 1'($urandom);
            mem_rd = (mem_read && !mem_waitrequest) ? v.mdata : $urandom;
            if (resp_valid) begin
                got = 1;
                chk("resp_cycle", c, v.cyc);
                chk("resp_err", resp_err, v.err);
                chk("resp_rdata", resp_rdata, v.rdata);
            end
            @(posedge clk); #1;
        end
        if (!got) chk("resp_seen", 0, 1);
        chk("strobe_cycles", idx, v.nstb);
        chk("both_strobes", both, 0);
        if (idx > 0) begin
            chk("mem_addr", a0, {v.addr[31:2], 2'b00});
            chk("byteenable", b0, v.be);
            chk("strobe_dir", wr0, v.write);
            chk("strobe_stable", unstable, 0);
            if (v.write) chk("writedata", w0, v.wd);
        end
        req_valid = 0;
        mem_waitrequest = 0;
    endtask
    initial begin
        vec_t r;
        rst_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; mem_rd = 0; mem_waitrequest = 0;
        tbl[0]  = mk(1, 2, 0, 'h10,  'hDEADBEEF, 0,           0,  'hF, 'hDEADBEEF, 0,           0, 2, 1);
        tbl[1]  = mk(0, 0, 1, 'h13,  0,          'h80FFFFFF,  0,  'h8, 0,          'hFFFFFF80,  0, 2, 1);
        tbl[2]  = mk(0, 0, 0, 'h13,  0,          'h80FFFFFF,  0,  'h8, 0,          'h00000080,  0, 2, 1);
        tbl[3]  = mk(1, 1, 0, 'h22,  'h0000ABCD, 0,           0,  'hC, 'hABCDABCD, 0,           0, 2, 1);
        tbl[4]  = mk(0, 2, 0, 'h05,  0,          'h11111111,  0,  0,   0,          0,           1, 1, 0);
        tbl[5]  = mk(0, 2, 0, 'h40,  0,          'h12345678,  3,  'hF, 0,          'h12345678,  0, 5, 4);
        tbl[6]  = mk(0, 2, 0, 'h44,  0,          'hCAFEF00D,  4,  'hF, 0,          'hCAFEF00D,  0, 6, 5);
        tbl[7]  = mk(0, 2, 0, 'h48,  0,          'hCAFEF00D,  99, 'hF, 0,          0,           1, 6, 5);
        tbl[8]  = mk(0, 3, 0, 'h50,  0,          0,           0,  0,   0,          0,           1, 1, 0);
        tbl[9]  = mk(0, 1, 1, 'h11,  0,          0,           0,  0,   0,          0,           1, 1, 0);
        tbl[10] = mk(0, 1, 1, 'h32,  0,          'h80011234,  0,  'hC, 0,          'hFFFF8001,  0, 2, 1);
        tbl[11] = mk(1, 0, 0, 'h101, 'h123456A5, 0,           2,  'h2, 'hA5A5A5A5, 0,           0, 4, 3);
        #3;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_byteenable", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_writedata", mem_wd, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) do_txn(tbl[i]);
        req_valid = 1; req_write = 0; req_size = 2; req_signed = 0; req_addr = 'h80; req_wdata = 0;
        @(posedge clk); #1;
        req_valid = 0;
        mem_waitrequest = 1;
        chk("pre_reset_read", mem_read, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("reset_drops_read", mem_read, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_no_resp", resp_valid, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("reset_hold_no_resp", resp_valid, 0);
        end
        @(negedge clk);
        rst_n = 1;
        mem_waitrequest = 0;
        do_txn(tbl[1]);
        for (int i = 0; i < 200; i++) begin
            r.write = 1'($urandom); r.size = 2'($urandom); r.sgn = 1'($urandom);
            r.addr = $urandom; r.wdata = $urandom; r.mdata = $urandom;
            r.stall = $urandom_range(0, TO + 2);
            do_txn(predict(r));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the maximum number of consecutive mem_waitrequest-high cycles before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_signed  in  1  load sign-extension enable; ignored for stores and word loads.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle response pulse.
REQ-012 resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid; misaligned, reserved size or timeout.
REQ-014 mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
REQ-015 mem_read / mem_write  out  1 each  access strobes; never both high.
REQ-016 mem_byteenable  out  4  lane mask; bit n selects bits [8n+7:8n], little-endian.
REQ-017 mem_writedata  out  32  lane-replicated store data.
REQ-018 mem_readdata  in  32  read data, valid in a cycle with mem_read high and mem_waitrequest low.
REQ-019 mem_waitrequest  in  1  memory stall; the access completes in the first strobe cycle with this input low.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP, ERR.
REQ-021 Accept a request on a cycle with req_valid && req_ready; latch all req_* fields that cycle.
REQ-022 On an accepted request that is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or uses size 11, go IDLE->ERR with no memory strobe.
REQ-023 On any other accepted request, go IDLE->ACCESS.
REQ-024 ERR lasts one cycle: resp_valid=1, resp_err=1, resp_rdata=0; then go to IDLE.
REQ-025 In ACCESS, drive mem_read or mem_write continuously with stable address, byteenable and writedata until mem_waitrequest is low.
REQ-026 On the completing ACCESS cycle, capture mem_readdata and go to RESP.
REQ-027 RESP lasts one cycle: resp_valid=1, resp_err=0; then go to IDLE.
REQ-028 Minimum latency: accept at cycle 0, strobe at cycle 1, resp_valid at cycle 2; the next accept is possible at cycle 3.
REQ-029 Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-030 mem_writedata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-031 Load extraction: select the addressed lane, then zero- or sign-extend to 32 bits per req_signed.
REQ-032 The wait counter clears on entry to ACCESS and increments on each waitrequest-high cycle.
REQ-033 When the wait counter reaches TIMEOUT_CYCLES, deassert the strobes the next cycle and go ACCESS->ERR.
REQ-034 A waitrequest drop on the same cycle the counter reaches its limit counts as completion, not timeout.
REQ-035 req_valid is ignored outside IDLE; requests are never queued.

Reset
REQ-036 While rst_n=0, asynchronously force: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_byteenable=0, mem_addr=0, mem_writedata=0, wait counter=0.
REQ-037 Reset asserted mid-ACCESS drops the strobes immediately, and no response is produced for that request.
REQ-038 The first accept after reset is possible on the first rising edge with rst_n=1.

Structure
REQ-039 Shared package lsu_pkg holds: the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and lane-mask constants.
REQ-040 Lane steering, byte-enable generation and load extension live in one combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-041 Word store: store addr 0x10, wdata 0xDEADBEEF, waitrequest 0 -> strobe at cycle 1 with mem_addr 0x10, byteenable 1111; resp_valid at cycle 2 with err=0.
REQ-042 Byte load, signed: addr 0x13, signed=1, mem_readdata 0x80FFFFFF -> byteenable 1000, resp_rdata 0xFFFFFF80; with signed=0 -> 0x00000080.
REQ-043 Half store: addr 0x22, wdata 0x0000ABCD -> byteenable 1100, mem_writedata 0xABCDABCD, mem_addr 0x20.
REQ-044 Misaligned load: word load at addr 0x05 -> no strobe, resp_valid and resp_err at cycle 1, resp_rdata 0.
REQ-045 Stall and timeout: waitrequest high 3 cycles then low -> strobe stable for 4 cycles, resp at cycle 5; with TIMEOUT_CYCLES=4 and waitrequest stuck high -> resp_err=1.
REQ-046 Reset mid-access: assert rst_n=0 during an ACCESS stall -> mem_read drops immediately, no resp_valid, and req_ready=1 after release.
